// File: rtl/usbls_tx_token_seq.sv
// USB low-speed token packet transmitter.
// Accepts a token request and streams SYNC, PID, ADDR and CRC bytes to a
// byte serializer, then holds off new tokens for an inter-packet gap.

// CRC5 over the 11-bit token payload {endp, addr}.
// Bits are consumed LSB first, in the same order they go on the wire.
// crc5_o[0] is the first CRC bit transmitted, so the packer can place
// crc5_o directly above endp[3:1] in an LSB-first byte.
module usbls_tx_crc5 (
   input  logic [10:0] data_i,
   output logic [4:0]  crc5_o
);

   // Serial LFSR for x^5 + x^2 + 1, seeded with all ones, unrolled over the payload
   always_comb begin : crcCalc
      logic [4:0] rem;
      rem = 5'h1F;
      for (int k = 0; k < 11; k++) begin
         if (rem[4] ^ data_i[k]) begin
            rem = {rem[3:0], 1'b0} ^ 5'b00101;
         end else begin
            rem = {rem[3:0], 1'b0};
         end
      end
      crc5_o = ~{rem[0], rem[1], rem[2], rem[3], rem[4]};
   end

endmodule

module usbls_tx_token_seq #(
   parameter int unsigned IPG_CYCLES = 16
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       tok_valid_i,
   output logic       tok_ready_o,
   input  logic [3:0] tok_pid_i,
   input  logic [6:0] tok_addr_i,
   input  logic [3:0] tok_endp_i,
   output logic [7:0] tx_data_o,
   output logic       tx_valid_o,
   input  logic       tx_ready_i,
   output logic       tx_last_o,
   output logic       tok_done_o,
   output logic       bad_pid_o,
   output logic       busy_o
);

   typedef enum logic [2:0] {
      StIdle,
      StSync,
      StPid,
      StAddr,
      StCrc,
      StGap
   } state_e;

   localparam logic [3:0] PidOut   = 4'b0001;
   localparam logic [3:0] PidIn    = 4'b1001;
   localparam logic [3:0] PidSetup = 4'b1101;
   localparam logic [7:0] SyncByte = 8'h80;
   localparam bit         HasGap   = (IPG_CYCLES != 0);
   localparam logic [7:0] GapLoad  = HasGap ? 8'(IPG_CYCLES - 1) : 8'd0;

   state_e     state_q, state_d;
   logic [3:0] pid_q, pid_d;
   logic [6:0] addr_q, addr_d;
   logic [3:0] endp_q, endp_d;
   logic [7:0] gapCnt_q, gapCnt_d;
   logic       tokDone_q, tokDone_d;
   logic       badPid_q, badPid_d;
   logic       pidValid;
   logic       tokReady;
   logic [4:0] crc5;

   // CRC is taken from the latched fields so it stays stable for the whole packet
   usbls_tx_crc5 u_crc5 (
      .data_i ({endp_q, addr_q}),
      .crc5_o (crc5)
   );

   // Next-state and byte mux; the pulse cycles after done/bad keep tok_ready low
   always_comb begin
      state_d    = state_q;
      pid_d      = pid_q;
      addr_d     = addr_q;
      endp_d     = endp_q;
      gapCnt_d   = gapCnt_q;
      tokDone_d  = 1'b0;
      badPid_d   = 1'b0;
      tx_valid_o = 1'b0;
      tx_last_o  = 1'b0;
      tx_data_o  = 8'h00;

      pidValid = (tok_pid_i == PidOut) || (tok_pid_i == PidIn) || (tok_pid_i == PidSetup);
      tokReady = (state_q == StIdle) && !tokDone_q && !badPid_q && !rst_i;

      case (state_q)
         StIdle: begin
            if (tok_valid_i && tokReady) begin
               pid_d  = tok_pid_i;
               addr_d = tok_addr_i;
               endp_d = tok_endp_i;
               if (pidValid) begin
                  state_d = StSync;
               end else begin
                  badPid_d = 1'b1;
               end
            end
         end
         StSync: begin
            tx_valid_o = 1'b1;
            tx_data_o  = SyncByte;
            if (tx_ready_i) begin
               state_d = StPid;
            end
         end
         StPid: begin
            tx_valid_o = 1'b1;
            tx_data_o  = {~pid_q, pid_q};
            if (tx_ready_i) begin
               state_d = StAddr;
            end
         end
         StAddr: begin
            tx_valid_o = 1'b1;
            tx_data_o  = {endp_q[0], addr_q};
            if (tx_ready_i) begin
               state_d = StCrc;
            end
         end
         StCrc: begin
            tx_valid_o = 1'b1;
            tx_last_o  = 1'b1;
            tx_data_o  = {crc5, endp_q[3:1]};
            if (tx_ready_i) begin
               tokDone_d = 1'b1;
               if (HasGap) begin
                  state_d  = StGap;
                  gapCnt_d = GapLoad;
               end else begin
                  state_d = StIdle;
               end
            end
         end
         StGap: begin
            if (gapCnt_q == 8'd0) begin
               state_d = StIdle;
            end else begin
               gapCnt_d = gapCnt_q - 8'd1;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      tok_ready_o = tokReady;
      tok_done_o  = tokDone_q;
      bad_pid_o   = badPid_q;
      busy_o      = (state_q != StIdle);
   end

   // State, latched token fields, gap counter and the one-cycle pulse flops
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= StIdle;
         pid_q     <= 4'd0;
         addr_q    <= 7'd0;
         endp_q    <= 4'd0;
         gapCnt_q  <= 8'd0;
         tokDone_q <= 1'b0;
         badPid_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         pid_q     <= pid_d;
         addr_q    <= addr_d;
         endp_q    <= endp_d;
         gapCnt_q  <= gapCnt_d;
         tokDone_q <= tokDone_d;
         badPid_q  <= badPid_d;
      end
   end

endmodule

// File: tb/tb_usbls_tx_token_seq.sv
// Testbench for usbls_tx_token_seq.
// Two instances (gap of 16 and gap of 0) share one stimulus stream; a
// packet-level model predicts each one's byte stream and handshakes.
module tb_usbls_tx_token_seq;

   localparam logic [3:0] PidOut   = 4'b0001;
   localparam logic [3:0] PidIn    = 4'b1001;
   localparam logic [3:0] PidSetup = 4'b1101;

   logic       clk;
   logic       rst;
   logic       tokValid;
   logic [3:0] tokPid;
   logic [6:0] tokAddr;
   logic [3:0] tokEndp;
   logic       txReady;

   logic       tokReady0, txValid0, txLast0, tokDone0, badPid0, busy0;
   logic       tokReady1, txValid1, txLast1, tokDone1, badPid1, busy1;
   logic [7:0] txData0, txData1;

   int testsRun;
   int testsFailed;

   // Model state per instance: remaining bytes of the packet in flight,
   // remaining gap cycles, and the pending done/bad pulses
   int         ipgOf   [2];
   int         left    [2];
   logic [7:0] pkt     [2][4];
   int         gapLeft [2];
   bit         doneP   [2];
   bit         badP    [2];

   bit         capOn;
   int         capCnt;
   logic [7:0] capBuf [16];

   usbls_tx_token_seq #(.IPG_CYCLES(16)) dutGap (
      .clk_i       (clk),
      .rst_i       (rst),
      .tok_valid_i (tokValid),
      .tok_ready_o (tokReady0),
      .tok_pid_i   (tokPid),
      .tok_addr_i  (tokAddr),
      .tok_endp_i  (tokEndp),
      .tx_data_o   (txData0),
      .tx_valid_o  (txValid0),
      .tx_ready_i  (txReady),
      .tx_last_o   (txLast0),
      .tok_done_o  (tokDone0),
      .bad_pid_o   (badPid0),
      .busy_o      (busy0)
   );

   usbls_tx_token_seq #(.IPG_CYCLES(0)) dutNoGap (
      .clk_i       (clk),
      .rst_i       (rst),
      .tok_valid_i (tokValid),
      .tok_ready_o (tokReady1),
      .tok_pid_i   (tokPid),
      .tok_addr_i  (tokAddr),
      .tok_endp_i  (tokEndp),
      .tx_data_o   (txData1),
      .tx_valid_o  (txValid1),
      .tx_ready_i  (txReady),
      .tx_last_o   (txLast1),
      .tok_done_o  (tokDone1),
      .bad_pid_o   (badPid1),
      .busy_o      (busy1)
   );

   // Free-running clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      testsRun++;
      if (observed !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
      end
   endtask

   // Reference CRC5 in reflected form (shift right, polynomial 0x14);
   // bit 0 of the result is the first CRC bit on the wire
   function automatic logic [4:0] refCrc5(input logic [6:0] a, input logic [3:0] e);
      logic [10:0] msg;
      logic [4:0]  r;
      msg = {e, a};
      r   = 5'h1F;
      for (int k = 0; k < 11; k++) begin
         if (r[0] ^ msg[k]) r = (r >> 1) ^ 5'h14;
         else               r = r >> 1;
      end
      return ~r;
   endfunction

   function automatic bit isTokenPid(input logic [3:0] p);
      return (p == PidOut) || (p == PidIn) || (p == PidSetup);
   endfunction

   function automatic bit expReady(input int i);
      return !rst && left[i] == 0 && gapLeft[i] == 0 && !doneP[i] && !badP[i];
   endfunction

   task automatic checkInstance(input int i);
      logic       oReady, oValid, oLast, oDone, oBad, oBusy;
      logic [7:0] oData;
      if (i == 0) begin
         oReady = tokReady0; oValid = txValid0; oLast = txLast0;
         oDone = tokDone0; oBad = badPid0; oBusy = busy0; oData = txData0;
      end else begin
         oReady = tokReady1; oValid = txValid1; oLast = txLast1;
         oDone = tokDone1; oBad = badPid1; oBusy = busy1; oData = txData1;
      end
      checkOutput($sformatf("tok_ready%0d", i), 32'(oReady), 32'(expReady(i)));
      checkOutput($sformatf("tx_valid%0d", i), 32'(oValid), 32'(left[i] > 0));
      checkOutput($sformatf("tok_done%0d", i), 32'(oDone), 32'(doneP[i]));
      checkOutput($sformatf("bad_pid%0d", i), 32'(oBad), 32'(badP[i]));
      checkOutput($sformatf("busy%0d", i), 32'(oBusy), 32'(left[i] > 0 || gapLeft[i] > 0));
      if (left[i] > 0) begin
         checkOutput($sformatf("tx_data%0d", i), 32'(oData), 32'(pkt[i][4 - left[i]]));
         checkOutput($sformatf("tx_last%0d", i), 32'(oLast), 32'(left[i] == 1));
      end else begin
         checkOutput($sformatf("tx_last%0d", i), 32'(oLast), 32'd0);
      end
   endtask

   task automatic updateModel(input int i);
      bit newDone;
      bit newBad;
      newDone = 1'b0;
      newBad  = 1'b0;
      if (rst) begin
         left[i]    = 0;
         gapLeft[i] = 0;
      end else if (left[i] > 0) begin
         if (txReady) begin
            left[i]--;
            if (left[i] == 0) begin
               newDone    = 1'b1;
               gapLeft[i] = ipgOf[i];
            end
         end
      end else if (gapLeft[i] > 0) begin
         gapLeft[i]--;
      end else if (tokValid && expReady(i)) begin
         if (isTokenPid(tokPid)) begin
            pkt[i][0] = 8'h80;
            pkt[i][1] = {~tokPid, tokPid};
            pkt[i][2] = {tokEndp[0], tokAddr};
            pkt[i][3] = {refCrc5(tokAddr, tokEndp), tokEndp[3:1]};
            left[i]   = 4;
         end else begin
            newBad = 1'b1;
         end
      end
      doneP[i] = newDone;
      badP[i]  = newBad;
   endtask

   // One clock cycle: drive inputs, check both instances, advance the model
   task automatic applyStimulus(input bit r, input bit tv, input logic [3:0] p,
                                input logic [6:0] a, input logic [3:0] e, input bit tr);
      rst      = r;
      tokValid = tv;
      tokPid   = p;
      tokAddr  = a;
      tokEndp  = e;
      txReady  = tr;
      #1;
      checkInstance(0);
      checkInstance(1);
      if (capOn && txValid0 && txReady && capCnt < 16) begin
         capBuf[capCnt] = txData0;
         capCnt++;
      end
      updateModel(0);
      updateModel(1);
      @(negedge clk);
   endtask

   task automatic checkCapture(input string tag, input logic [7:0] b0, input logic [7:0] b1,
                               input logic [7:0] b2, input logic [7:0] b3, input int n);
      logic [7:0] want [4];
      want = '{b0, b1, b2, b3};
      checkOutput({tag, "_count"}, 32'(capCnt), 32'(n));
      for (int k = 0; k < n && k < 4; k++) begin
         checkOutput($sformatf("%s_byte%0d", tag, k), 32'(capBuf[k]), 32'(want[k]));
      end
   endtask

   // Directed scenarios followed by a long randomized run
   initial begin
      testsRun    = 0;
      testsFailed = 0;
      ipgOf[0] = 16;
      ipgOf[1] = 0;
      for (int i = 0; i < 2; i++) begin
         left[i] = 0; gapLeft[i] = 0; doneP[i] = 1'b0; badP[i] = 1'b0;
      end
      capOn  = 1'b0;
      capCnt = 0;
      rst = 1'b1; tokValid = 1'b0; tokPid = 4'd0; tokAddr = 7'd0; tokEndp = 4'd0; txReady = 1'b0;
      @(negedge clk);

      for (int c = 0; c < 3; c++) applyStimulus(1, 0, 4'd0, 7'd0, 4'd0, 0);

      // OUT addr 1 endp 2 with a ready serializer
      capOn = 1'b1; capCnt = 0;
      applyStimulus(0, 1, PidOut, 7'h01, 4'h2, 1);
      for (int c = 0; c < 24; c++) applyStimulus(0, 0, PidOut, 7'h01, 4'h2, 1);
      capOn = 1'b0;
      checkCapture("out_pkt", 8'h80, 8'hE1, 8'h01, 8'hC1, 4);

      // IN addr 1 endp 2 with tx_ready toggling
      capOn = 1'b1; capCnt = 0;
      applyStimulus(0, 1, PidIn, 7'h01, 4'h2, 0);
      for (int c = 0; c < 12; c++) applyStimulus(0, 0, PidIn, 7'h01, 4'h2, (c % 2) == 0);
      for (int c = 0; c < 20; c++) applyStimulus(0, 0, PidIn, 7'h01, 4'h2, 1);
      capOn = 1'b0;
      checkCapture("in_pkt", 8'h80, 8'h69, 8'h01, 8'hC1, 4);

      // Non-token PID, then a SETUP token
      applyStimulus(0, 1, 4'b0011, 7'h05, 4'h3, 1);
      for (int c = 0; c < 3; c++) applyStimulus(0, 0, 4'b0011, 7'h05, 4'h3, 1);
      capOn = 1'b1; capCnt = 0;
      applyStimulus(0, 1, PidSetup, 7'h01, 4'h2, 1);
      for (int c = 0; c < 24; c++) applyStimulus(0, 0, PidSetup, 7'h01, 4'h2, 1);
      capOn = 1'b0;
      checkCapture("setup_pkt", 8'h80, 8'h2D, 8'h01, 8'hC1, 4);

      // Reset while the ADDR byte is stalled, then a fresh token
      applyStimulus(0, 1, PidOut, 7'h33, 4'h9, 1);
      applyStimulus(0, 0, PidOut, 7'h33, 4'h9, 1);
      applyStimulus(0, 0, PidOut, 7'h33, 4'h9, 1);
      for (int c = 0; c < 3; c++) applyStimulus(0, 0, PidOut, 7'h33, 4'h9, 0);
      applyStimulus(1, 0, PidOut, 7'h33, 4'h9, 0);
      applyStimulus(0, 1, PidIn, 7'h2A, 4'h7, 1);
      for (int c = 0; c < 24; c++) applyStimulus(0, 0, PidIn, 7'h2A, 4'h7, 1);

      // tok_valid held high: back-to-back tokens
      for (int c = 0; c < 48; c++) applyStimulus(0, 1, PidOut, 7'h11, 4'hC, 1);
      for (int c = 0; c < 20; c++) applyStimulus(0, 0, PidOut, 7'h11, 4'hC, 1);

      // Randomized traffic with occasional resets, bad PIDs and stalls
      for (int c = 0; c < 4000; c++) begin
         logic [3:0] p;
         int         sel;
         sel = $urandom_range(0, 5);
         case (sel)
            0:       p = PidOut;
            1:       p = PidIn;
            2:       p = PidSetup;
            3:       p = PidIn;
            default: p = 4'($urandom_range(0, 15));
         endcase
         applyStimulus($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, p,
                       7'($urandom_range(0, 127)), 4'($urandom_range(0, 15)),
                       $urandom_range(0, 3) != 0);
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/usbls_tx_token_seq.md
USBLS_TX_TOKEN_SEQ -- requirements
Module: usbls_tx_token_seq

Interface
REQ-001 Parameter IPG_CYCLES, default 16: idle clock cycles enforced after a token's last byte before the next token is accepted (valid range 0..255).
REQ-002 clk  input  1  single system clock; all logic is clocked on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 tok_valid  input  1  requester offers a token.
REQ-005 tok_ready  output  1  block accepts a token this cycle.
REQ-006 tok_pid  input  4  PID nibble; OUT=4'b0001, IN=4'b1001, SETUP=4'b1101.
REQ-007 tok_addr  input  7  device address.
REQ-008 tok_endp  input  4  endpoint number.
REQ-009 tx_data  output  8  byte to the serializer, LSB transmitted first.
REQ-010 tx_valid  output  1  tx_data is valid.
REQ-011 tx_ready  input  1  serializer consumes the byte this cycle.
REQ-012 tx_last  output  1  current byte is the final byte of the packet.
REQ-013 tok_done  output  1  one-cycle pulse when the final byte is consumed.
REQ-014 bad_pid  output  1  one-cycle pulse when a non-token PID is rejected.
REQ-015 busy  output  1  high in every state except IDLE.

Function
REQ-016 FSM states: IDLE, SYNC, PID, ADDR, CRC, GAP.
REQ-017 tok_ready SHALL be 1 only in IDLE; a token is accepted on tok_valid & tok_ready; tok_pid, tok_addr and tok_endp are latched on acceptance and ignored afterwards.
REQ-018 Accepted valid PID: IDLE -> SYNC. tx_valid is 1 in the cycle immediately after acceptance (latency 1).
REQ-019 Accepted PID not in {OUT, IN, SETUP}: bad_pid pulses in the next cycle, no bytes are emitted, and the FSM stays in IDLE; tok_ready returns to 1 in the following cycle.
REQ-020 Byte sequence: SYNC=8'h80; PID={~pid,pid}; ADDR={endp[0],addr[6:0]}; CRC={crc5[4:0],endp[3:1]}.
REQ-021 crc5 SHALL come from an instance of usbls_tx_crc5 with data={endp,addr}, driven from the latched registers.
REQ-022 In SYNC/PID/ADDR/CRC, tx_valid=1; the FSM advances only on tx_valid & tx_ready.
REQ-023 tx_data and tx_last SHALL remain stable while tx_valid & ~tx_ready.
REQ-024 tx_last=1 only in CRC.
REQ-025 CRC consumed: tok_done pulses in the next cycle; go to GAP if IPG_CYCLES>0, else go to IDLE.
REQ-026 GAP: an 8-bit counter loads IPG_CYCLES-1 on entry and decrements each cycle; exit to IDLE when the count is 0, giving exactly IPG_CYCLES cycles in GAP.
REQ-027 tx_valid=0 in IDLE and GAP; tx_ready is ignored there.
REQ-028 Asserting tok_valid outside IDLE has no effect; the requester must hold it until accepted.
REQ-029 tx_ready held at 0 indefinitely stalls the FSM in its current byte state with outputs unchanged; there is no timeout.
REQ-030 tok_done and bad_pid SHALL never be asserted in the same cycle.

Reset
REQ-031 With rst=1 at a clock edge: FSM -> IDLE, GAP counter=0, latched fields=0, and tx_valid, tx_last, tok_done, bad_pid, busy=0.
REQ-032 tok_ready SHALL be 0 while rst=1 and 1 in the first cycle after rst deasserts.
REQ-033 rst in any state, including mid-packet or in GAP, aborts the packet immediately; no further bytes or pulses follow, and tx_valid=0 in the cycle after the reset edge.

Verification
REQ-034 OUT, addr=7'h01, endp=4'h2, tx_ready=1 -> bytes 80,E1,01,C1 on consecutive cycles; tx_last only on C1; tok_done 1 cycle later; tok_ready returns after 16 GAP cycles.
REQ-035 IN, addr=7'h01, endp=4'h2, tx_ready toggling 1/0 -> bytes 80,69,01,C1, each held stable through stall cycles, with no byte dropped or duplicated.
REQ-036 tok_pid=4'b0011 -> bad_pid single pulse, tx_valid stays 0, tok_ready back to 1 after 2 cycles; a SETUP token then emits 80,2D,...
REQ-037 rst asserted while the ADDR byte is stalled -> tx_valid=0 the next cycle, no tok_done; after release, a new token is sent from SYNC.
REQ-038 IPG_CYCLES=0, back-to-back tokens with tok_valid held high -> second SYNC appears 2 cycles after the first packet's CRC byte is consumed (tok_done cycle, then the IDLE accept cycle).
